exec_seq: RTL and testbench



---
 rtl/exec_seq.sv | 209 ++++++++++++++++++++
 tb/tb_exec_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_seq.sv
// Command sequencer for the exec stage: turns valid/ready macro-commands into
// the registered per-cycle control vector (r, e, selects, reset, next, op).
module exec_seq #(
  parameter int OP_SIZE  = 32,
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_code,
  input  logic [OP_SIZE-1:0] cmd_data,
  input  logic               computation_end,
  output logic               r,
  output logic               e,
  output logic               o1,
  output logic               o2,
  output logic               w1,
  output logic               w2,
  output logic               reset,
  output logic               next,
  output logic [OP_SIZE-1:0] op,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, so every command
  // is followed by at least one IDLE cycle before the next can be taken.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  typedef struct packed {
    logic r;
    logic e;
    logic o1;
    logic o2;
    logic w1;
    logic w2;
    logic reset;
    logic next;
  } ctrl_t;

  localparam logic [2:0] OPC_LOAD_O1  = 3'd0;
  localparam logic [2:0] OPC_LOAD_O2  = 3'd1;
  localparam logic [2:0] OPC_LOAD_W1  = 3'd2;
  localparam logic [2:0] OPC_LOAD_W2  = 3'd3;
  localparam logic [2:0] OPC_RUN      = 3'd4;
  localparam logic [2:0] OPC_REWIND   = 3'd5;
  localparam logic [2:0] OPC_NEXT     = 3'd6;
  localparam logic [2:0] OPC_WAIT_END = 3'd7;

  localparam int DRAIN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_LAT);

  localparam ctrl_t CTRL_MAC = '{r: 1'b1, e: 1'b1, o1: 1'b1, o2: 1'b1,
                                 w1: 1'b1, w2: 1'b1, reset: 1'b0, next: 1'b0};
  localparam ctrl_t CTRL_ACC = '{r: 1'b0, e: 1'b1, o1: 1'b0, o2: 1'b0,
                                 w1: 1'b0, w2: 1'b0, reset: 1'b0, next: 1'b0};
  localparam ctrl_t CTRL_WB  = '{r: 1'b0, e: 1'b1, o1: 1'b1, o2: 1'b0,
                                 w1: 1'b0, w2: 1'b0, reset: 1'b0, next: 1'b0};
  localparam ctrl_t CTRL_RWD = '{r: 1'b0, e: 1'b0, o1: 1'b1, o2: 1'b1,
                                 w1: 1'b0, w2: 1'b0, reset: 1'b1, next: 1'b0};
  localparam ctrl_t CTRL_NXT = '{r: 1'b0, e: 1'b0, o1: 1'b1, o2: 1'b1,
                                 w1: 1'b0, w2: 1'b0, reset: 1'b0, next: 1'b1};

  state_t             state, state_d;
  logic [CNT_W-1:0]   run_cnt, run_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [OP_SIZE-1:0] op_d;
  logic               done_d;
  logic [CNT_W-1:0]   run_n;

  assign run_n = cmd_data[CNT_W-1:0];

  // Next-state logic also produces the control vector for the coming cycle,
  // so every output leaves a flop.
  always_comb begin
    state_d     = state;
    run_cnt_d   = run_cnt;
    drain_cnt_d = drain_cnt;
    ctrl_d      = '0;
    op_d        = '0;
    done_d      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_code)
            OPC_LOAD_O1, OPC_LOAD_O2, OPC_LOAD_W1, OPC_LOAD_W2: begin
              state_d   = S_ISSUE;
              op_d      = cmd_data;
              done_d    = 1'b1;
              ctrl_d.o1 = (cmd_code == OPC_LOAD_O1);
              ctrl_d.o2 = (cmd_code == OPC_LOAD_O2);
              ctrl_d.w1 = (cmd_code == OPC_LOAD_W1);
              ctrl_d.w2 = (cmd_code == OPC_LOAD_W2);
            end
            OPC_RUN: begin
              if (run_n == '0) begin
                state_d = S_ISSUE;
                done_d  = 1'b1;
              end else begin
                state_d   = S_RUN;
                run_cnt_d = run_n;
                ctrl_d    = CTRL_MAC;
              end
            end
            OPC_REWIND: begin
              state_d = S_ISSUE;
              ctrl_d  = CTRL_RWD;
              done_d  = 1'b1;
            end
            OPC_NEXT: begin
              state_d = S_ISSUE;
              ctrl_d  = CTRL_NXT;
              done_d  = 1'b1;
            end
            OPC_WAIT_END: begin
              // computation_end already seen: the first WAIT cycle is the done cycle
              if (computation_end) begin
                state_d = S_ISSUE;
                done_d  = 1'b1;
              end else begin
                state_d = S_WAIT;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_ISSUE: state_d = S_IDLE;
      S_RUN: begin
        if (run_cnt == CNT_W'(1)) begin
          if (PIPE_LAT == 0) begin
            state_d = S_WB;
            ctrl_d  = CTRL_WB;
            done_d  = 1'b1;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_INIT;
            ctrl_d      = CTRL_ACC;
          end
        end else begin
          run_cnt_d = run_cnt - CNT_W'(1);
          ctrl_d    = CTRL_MAC;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_W'(1)) begin
          state_d = S_WB;
          ctrl_d  = CTRL_WB;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt - DRAIN_W'(1);
          ctrl_d      = CTRL_ACC;
        end
      end
      S_WB: state_d = S_IDLE;
      S_WAIT: begin
        if (computation_end) begin
          state_d = S_ISSUE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      run_cnt   <= '0;
      drain_cnt <= '0;
      ctrl_q    <= '0;
      op        <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      run_cnt   <= run_cnt_d;
      drain_cnt <= drain_cnt_d;
      ctrl_q    <= ctrl_d;
      op        <= op_d;
      done      <= done_d;
    end
  end

  assign r         = ctrl_q.r;
  assign e         = ctrl_q.e;
  assign o1        = ctrl_q.o1;
  assign o2        = ctrl_q.o2;
  assign w1        = ctrl_q.w1;
  assign w2        = ctrl_q.w2;
  assign reset     = ctrl_q.reset;
  assign next      = ctrl_q.next;
  assign busy      = (state != S_IDLE);
  assign cmd_ready = ~busy;
  assign dbg_state = state;

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: commands are expanded by a cycle-list reference model
// into an expected queue that a negedge monitor consumes.
module tb_exec_seq;
  localparam int OP_SIZE  = 32;
  localparam int CNT_W    = 8;
  localparam int PIPE_LAT = 2;
  localparam int VW       = OP_SIZE + 9;

  // control bit order: {r, e, o1, o2, w1, w2, reset, next}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_MAC  = 8'b1111_1100;
  localparam logic [7:0] C_ACC  = 8'b0100_0000;
  localparam logic [7:0] C_WB   = 8'b0110_0000;
  localparam logic [7:0] C_RWD  = 8'b0011_0010;
  localparam logic [7:0] C_NXT  = 8'b0011_0001;
  localparam logic [7:0] C_LD0  = 8'b0010_0000;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_code;
  logic [OP_SIZE-1:0] cmd_data;
  logic               computation_end;
  logic               r, e, o1, o2, w1, w2, reset, next;
  logic [OP_SIZE-1:0] op;
  logic               busy, done;
  logic [2:0]         dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] act;
  logic [VW-1:0] exp_v;
  logic          exp_busy;

  exec_seq #(.OP_SIZE(OP_SIZE), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .computation_end(computation_end),
    .r(r), .e(e), .o1(o1), .o2(o2), .w1(w1), .w2(w2), .reset(reset),
    .next(next), .op(op), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  assign act = {r, e, o1, o2, w1, w2, reset, next, done, op};

  function automatic logic [VW-1:0] mk(input logic [7:0] c, input logic dn,
                                        input logic [OP_SIZE-1:0] d);
    return {c, dn, d};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] a, input logic [VW-1:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, a, x, $time);
    end
  endtask

  // Reference model: the list of cycles each command occupies.
  task automatic expect_cmd(input logic [2:0] code, input logic [OP_SIZE-1:0] data,
                            input logic ce_pre, input int d);
    int n;
    case (code)
      3'd0, 3'd1, 3'd2, 3'd3: exp_q.push_back(mk(C_LD0 >> code, 1'b1, data));
      3'd4: begin
        n = int'(data[CNT_W-1:0]);
        if (n == 0) exp_q.push_back(mk(C_NONE, 1'b1, '0));
        else begin
          for (int i = 0; i < n; i++) exp_q.push_back(mk(C_MAC, 1'b0, '0));
          for (int i = 0; i < PIPE_LAT; i++) exp_q.push_back(mk(C_ACC, 1'b0, '0));
          exp_q.push_back(mk(C_WB, 1'b1, '0));
        end
      end
      3'd5: exp_q.push_back(mk(C_RWD, 1'b1, '0));
      3'd6: exp_q.push_back(mk(C_NXT, 1'b1, '0));
      default: begin
        if (!ce_pre)
          for (int i = 0; i <= d; i++) exp_q.push_back(mk(C_NONE, 1'b0, '0));
        exp_q.push_back(mk(C_NONE, 1'b1, '0));
      end
    endcase
  endtask

  // Offers one command; for WAIT_END, d is the number of cycles after
  // acceptance before computation_end is raised.
  task automatic send(input logic [2:0] code, input logic [OP_SIZE-1:0] data,
                      input bit hold, input int d, input bit ce_pre);
    bit accepted = 0;
    bit rdy;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    if (code == 3'd7) computation_end = ce_pre;
    else computation_end = 1'($urandom_range(0, 1));
    for (int i = 0; i < 400 && !accepted; i++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) accepted = 1;
      else #1;
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout code=%0d actual=not_accepted required=accepted", code);
      cmd_valid = 1'b0;
      return;
    end
    expect_cmd(code, data, ce_pre, d);
    #1;
    if (code == 3'd7) begin
      if (ce_pre) computation_end = 1'b0;
      else begin
        repeat (d) @(posedge clk);
        #1 computation_end = 1'b1;
        @(posedge clk);
        #1 computation_end = 1'b0;
      end
    end
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_code  = 3'($urandom);
      cmd_data  = $urandom;
    end
  endtask

  // Monitor: the DUT must be busy exactly while the model has cycles queued.
  always @(negedge clk) begin
    exp_busy = (exp_q.size() != 0);
    check("busy", VW'(busy), VW'(exp_busy));
    check("cmd_ready", VW'(cmd_ready), VW'(!exp_busy));
    if (exp_busy) begin
      exp_v = exp_q.pop_front();
      check("vector", act, exp_v);
    end else begin
      check("idle_vector", act, '0);
      check("idle_state", VW'(dbg_state), '0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] code;
    logic [OP_SIZE-1:0] data;
    rst             = 1'b1;
    cmd_valid       = 1'b0;
    cmd_code        = '0;
    cmd_data        = '0;
    computation_end = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Abort RUN N=10 with an asynchronous reset held for three cycles.
    send(3'd4, 32'h0000_000A, 0, 0, 0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async_vector", act, '0);
    check("rst_async_busy", VW'(busy), '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("rst_release_ready", VW'(cmd_ready), VW'(1'b1));
    send(3'd0, 32'hDEAD_BEEF, 0, 0, 0);

    send(3'd3, 32'h0001_8000, 0, 0, 0);
    send(3'd4, 32'h0000_0005, 0, 0, 0);
    send(3'd4, 32'hABCD_0100, 0, 0, 0);
    send(3'd4, 32'h0000_0001, 0, 0, 0);
    send(3'd4, 32'h1234_56FF, 0, 0, 0);
    send(3'd5, 32'h0, 1, 0, 0);
    send(3'd6, 32'h0, 0, 0, 0);
    send(3'd7, 32'h0, 0, 7, 0);
    send(3'd7, 32'h0, 0, 0, 1);
    send(3'd7, 32'h0, 0, 0, 0);
    send(3'd1, 32'h5A5A_A5A5, 1, 0, 0);
    send(3'd2, 32'h0000_0000, 0, 0, 0);

    for (int k = 0; k < 80; k++) begin
      code = 3'($urandom_range(0, 7));
      data = $urandom;
      if (code == 3'd4) data[CNT_W-1:0] = CNT_W'($urandom_range(0, 12));
      send(code, data, 1'($urandom_range(0, 1)), $urandom_range(0, 5),
           1'($urandom_range(0, 3) == 0));
    end

    cmd_valid = 1'b0;
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", VW'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
